// File: rtl/aes_bram_pkg.sv
// Shared types and sizes for the x26_x49 masked S-box BRAM stage.
package aes_bram_pkg;

  localparam int BRAM_ADDR_W     = 10;
  localparam int BRAM_DATA_W     = 8;
  localparam int BYTES_PER_STATE = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH0 = 2'd1,
    FLUSH1 = 2'd2
  } feed_state_e;

endpackage

// File: rtl/x26_x49_lat_pipe.sv
// Valid/last shift register that tracks the BRAM read latency; frozen when adv is low.
module x26_x49_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] last_r;

  // Shift in the handshake flag and its last marker whenever the BRAM pipe advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      last_r  <= '0;
    end else if (adv) begin
      valid_r <= {valid_r[DEPTH-2:0], in_valid};
      last_r  <= {last_r[DEPTH-2:0], in_last};
    end else begin
      valid_r <= valid_r;
      last_r  <= last_r;
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_last  = last_r[DEPTH-1];

endmodule

// File: rtl/x26_x49_bram_feeder.sv
// Sequencer feeding two-share masked bytes into the x26_x49 S-box BRAM pair.
// Optional X26_X49_ZERO_FLUSH_EN: two address-0 dummy reads after every state.
module x26_x49_bram_feeder
  import aes_bram_pkg::*;
#(
  parameter int BYTES_PER_STATE = aes_bram_pkg::BYTES_PER_STATE,
  parameter int LAT             = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BRAM_DATA_W-1:0] in_s0,
  input  logic [BRAM_DATA_W-1:0] in_s1,
  input  logic [3:0]             in_r,
  output logic [BRAM_ADDR_W-1:0] bram_addra,
  output logic [BRAM_ADDR_W-1:0] bram_addrb,
  output logic                   bram_en,
  output logic                   bram_rst,
  input  logic [BRAM_DATA_W-1:0] bram_doa,
  input  logic [BRAM_DATA_W-1:0] bram_dob,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BRAM_DATA_W-1:0] out_s0,
  output logic [BRAM_DATA_W-1:0] out_s1,
  output logic                   out_last
);

  localparam int              CNT_W    = $clog2(BYTES_PER_STATE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_STATE - 1);

  feed_state_e      state_r;
  feed_state_e      state_nxt_s;
  logic [CNT_W-1:0] byte_cnt_r;
  logic             bram_rst_r;
  logic             adv_s;
  logic             fire_s;
  logic             last_in_s;

  // BRAM reset follows rst and lingers one clock after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bram_rst_r <= 1'b1;
    end else begin
      bram_rst_r <= 1'b0;
    end
  end

  // BRAM registers, valid pipe and enable all move together or not at all
  assign adv_s    = !(out_valid && !out_ready) && !bram_rst_r;
  assign bram_en  = adv_s;
  assign bram_rst = bram_rst_r;

  // Next state, handshake and address gating; share data only reaches the BRAM on a fire
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    fire_s      = 1'b0;
    bram_addra  = {BRAM_ADDR_W{1'b0}};
    bram_addrb  = {BRAM_ADDR_W{1'b0}};
    case (state_r)
      RUN: begin
        in_ready = adv_s;
        fire_s   = in_valid && adv_s;
        if (fire_s) begin
          bram_addra = {in_r[1:0], in_s0};
          bram_addrb = {in_r[3:2], in_s1};
`ifdef X26_X49_ZERO_FLUSH_EN
          if (byte_cnt_r == CNT_LAST) begin
            state_nxt_s = FLUSH0;
          end else begin
            state_nxt_s = RUN;
          end
`endif
        end else begin
          bram_addra = {BRAM_ADDR_W{1'b0}};
          bram_addrb = {BRAM_ADDR_W{1'b0}};
        end
      end
`ifdef X26_X49_ZERO_FLUSH_EN
      FLUSH0: begin
        if (adv_s) begin
          state_nxt_s = FLUSH1;
        end else begin
          state_nxt_s = FLUSH0;
        end
      end
      FLUSH1: begin
        if (adv_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FLUSH1;
        end
      end
`endif
      default: state_nxt_s = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Position of the next accepted byte within its AES state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_r <= '0;
    end else if (fire_s) begin
      byte_cnt_r <= byte_cnt_r + CNT_W'(1);
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  assign last_in_s = fire_s && (byte_cnt_r == CNT_LAST);

  x26_x49_lat_pipe #(
    .DEPTH (LAT)
  ) u_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv_s),
    .in_valid  (fire_s),
    .in_last   (last_in_s),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  assign out_s0 = bram_doa;
  assign out_s1 = bram_dob;

endmodule

// File: doc/x26_x49_bram_feeder.md
# x26_x49_bram_feeder

Upstream sequencer for the x26_x49 masked S-box BRAM stage of the 5-serial AES encryption core. Accepts one two-share masked byte per handshake, forms the two 10-bit BRAM addresses, drives the shared enable and synchronous reset, and tracks the BRAM's 2-cycle registered read latency. It presents the two 8-bit share outputs downstream with valid/ready flow control and a last flag on every 16th byte.

## Interface
Parameters:
- BYTES_PER_STATE, 16, bytes per AES state; must be a power of two.
- LAT, 2, BRAM read latency in cycles (DOA_REG = DOB_REG = 1); fixed at 2.

Ports:
- clk  in  1  single clock; also drives both BRAM ports.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  masked byte offered.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_s0  in  8  share 0 of masked byte.
- in_s1  in  8  share 1 of masked byte.
- in_r  in  4  fresh randomness: [1:0] selects the port-A table, [3:2] selects the port-B table.
- bram_addra  out  10  {in_r[1:0], in_s0}.
- bram_addrb  out  10  {in_r[3:2], in_s1}.
- bram_en  out  1  BRAM ENA/ENB/REGCEA/REGCEB.
- bram_rst  out  1  BRAM RSTA/RSTB, active-high, synchronous at the BRAM.
- bram_doa  in  8  BRAM port-A data.
- bram_dob  in  8  BRAM port-B data.
- out_valid  out  1  output shares valid.
- out_ready  in  1  downstream accepts.
- out_s0  out  8  equals bram_doa.
- out_s1  out  8  equals bram_dob.
- out_last  out  1  high with the final byte of a state.

## Operation
- adv = !(out_valid && !out_ready). Drive bram_en = adv. Stalling freezes both BRAM pipeline registers together with the valid pipe.
- in_ready = adv && (state == RUN) && !bram_rst.
- Valid pipe: v[0] <= fire, v[1] <= v[0], both updated only when adv. out_valid = v[1]. A parallel last pipe carries (byte_cnt == BYTES_PER_STATE-1) && fire.
- Addresses are purely combinational from the inputs while in RUN. In FLUSH states they are forced to 10'h000. In every other cycle where fire is low they are held at 10'h000, so no share data reaches the BRAM address lines without a handshake.
- byte_cnt: 4 bits, increments on fire, wraps 15 -> 0.
- bram_rst is high while rst is low and for exactly one clk cycle after rst deasserts. in_ready is low during that cycle.
- FSM states: RUN, FLUSH0, FLUSH1. FLUSH0 and FLUSH1 exist only with the configuration macro defined. RUN -> FLUSH0 on a fire with byte_cnt == 15. FLUSH0 -> FLUSH1 -> RUN, each transition taken only when adv. Flush reads do not set v[0].
- Simultaneous in_valid and a stall (adv = 0): no fire, and addresses and counter hold.

## Timing
- Reset values: in_ready 0, bram_en 0, bram_rst 1, bram_addra and bram_addrb 0, out_valid 0, out_last 0, byte_cnt 0, state RUN.
- Latency: a fire in cycle t gives out_valid in cycle t+2, with no stall in between. Each stalled cycle adds exactly one cycle.
- Throughput: one byte per cycle in RUN. Without the macro, 16 bytes take 16 cycles. With the macro, 16 bytes take 18 cycles.
- Reset asserted mid-operation: all state clears asynchronously and in-flight bytes are dropped. No out_valid may appear after reset.

## Configuration
- X26_X49_ZERO_FLUSH_EN defined: after every 16th byte, insert two dummy reads at address 0. These precharge the BRAM output registers to a data-independent value, which suppresses transition leakage between states.
- Undefined: FLUSH states are absent and bytes stream back-to-back across state boundaries.

## Structure
- Shared package aes_bram_pkg holds:
  - the state enum (RUN, FLUSH0, FLUSH1);
  - BRAM_ADDR_W = 10 and BRAM_DATA_W = 8;
  - BYTES_PER_STATE.
- One sub-module, x26_x49_lat_pipe: a 2-deep valid/last shift register with an advance enable.
- The BRAM instance is not inside this block. It is connected alongside it at the next level up.

## Test plan
- Reset, then one byte s0=0x3A, s1=0x51, r=0x6: addra=0x23A and addrb=0x151 in the fire cycle; out_valid in cycle +2 with the BRAM table data. Checked against a behavioural BRAM model.
- 16 back-to-back bytes with out_ready tied high: out_last only on the 16th output. With the macro, in_ready is low for exactly 2 cycles after the 16th fire and addresses read 0 during that gap.
- out_ready held low for 3 cycles while output data is valid: bram_en is 0 during those cycles, out_s0 and out_s1 stay stable, and no byte is lost or duplicated.
- rst pulsed low while 2 bytes are in flight: out_valid stays 0 afterwards, bram_rst is high for one cycle after release, and byte_cnt restarts at 0.
- Random in_valid and out_ready over 1000 bytes: the output sequence equals the scoreboard sequence, and out_last appears every 16 bytes.
